// File: rtl/alu_pkg.sv
// Shared definitions for the integer ALU and its two-requester arbiter:
// opcode encodings ({funct7, 1'b0, funct3}), requester id type and legality check.
package alu_pkg;

    localparam int OP_W   = 11;
    localparam int DATA_W = 32;

    localparam logic [OP_W-1:0] ALU_ADD = 11'h000;
    localparam logic [OP_W-1:0] ALU_SUB = 11'h200;
    localparam logic [OP_W-1:0] ALU_SLL = 11'h001;
    localparam logic [OP_W-1:0] ALU_SLT = 11'h002;
    localparam logic [OP_W-1:0] ALU_XOR = 11'h004;
    localparam logic [OP_W-1:0] ALU_SRL = 11'h005;
    localparam logic [OP_W-1:0] ALU_SRA = 11'h205;
    localparam logic [OP_W-1:0] ALU_OR  = 11'h006;
    localparam logic [OP_W-1:0] ALU_AND = 11'h007;

    typedef logic req_id_t;

    localparam req_id_t REQ_EX  = 1'b0;
    localparam req_id_t REQ_AUX = 1'b1;

    function automatic logic is_legal_alu_op(input logic [OP_W-1:0] op);
        logic legal;
        case (op)
            ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_XOR,
            ALU_SRL, ALU_SRA, ALU_OR, ALU_AND: legal = 1'b1;
            default:                           legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit integer ALU. Any opcode outside the legal set yields 0.
module alu
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    logic [4:0] shamt_s;

    assign shamt_s = b[4:0];

    // Opcode decode and datapath
    always_comb begin
        result = 32'h0000_0000;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLL: result = a << shamt_s;
            ALU_SLT: result = {31'h0000_0000, ($signed(a) < $signed(b))};
            ALU_XOR: result = a ^ b;
            ALU_SRL: result = a >> shamt_s;
            ALU_SRA: result = $unsigned($signed(a) >>> shamt_s);
            ALU_OR:  result = a | b;
            ALU_AND: result = a & b;
            default: result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between the execute pipeline and the aux helper,
// with a one-entry response register and a saturating contention counter.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [TAG_W-1:0]  req1_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output req_id_t           rsp_id,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_illegal,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic              can_accept_s;
    logic              both_valid_s;
    logic              grant_valid_s;
    req_id_t           grant_id_s;
    logic [OP_W-1:0]   mux_op_s;
    logic [DATA_W-1:0] mux_a_s;
    logic [DATA_W-1:0] mux_b_s;
    logic [TAG_W-1:0]  mux_tag_s;
    logic [DATA_W-1:0] alu_result_s;
    logic              illegal_s;

    req_id_t           last_grant_r;
    logic              rsp_valid_r;
    req_id_t           rsp_id_r;
    logic [TAG_W-1:0]  rsp_tag_r;
    logic [DATA_W-1:0] rsp_result_r;
    logic              rsp_zero_r;
    logic              rsp_illegal_r;
    logic [CNT_W-1:0]  conflict_cnt_r;

    // The slot frees in the same cycle the consumer drains it, giving 1 op/cycle.
    assign can_accept_s = !rsp_valid_r || rsp_ready;
    assign both_valid_s = req0_valid && req1_valid;

    // Round-robin grant: on contention the requester that did not win last goes first
    always_comb begin
        grant_valid_s = 1'b0;
        grant_id_s    = REQ_EX;
        if (rst || !can_accept_s) begin
            grant_valid_s = 1'b0;
        end else if (both_valid_s) begin
            grant_valid_s = 1'b1;
            grant_id_s    = ~last_grant_r;
        end else if (req0_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = REQ_EX;
        end else if (req1_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = REQ_AUX;
        end else begin
            grant_valid_s = 1'b0;
        end
    end

    assign req0_ready = grant_valid_s && (grant_id_s == REQ_EX);
    assign req1_ready = grant_valid_s && (grant_id_s == REQ_AUX);

    // Operand mux in front of the shared ALU
    always_comb begin
        if (grant_id_s == REQ_AUX) begin
            mux_op_s  = req1_op;
            mux_a_s   = req1_a;
            mux_b_s   = req1_b;
            mux_tag_s = req1_tag;
        end else begin
            mux_op_s  = req0_op;
            mux_a_s   = req0_a;
            mux_b_s   = req0_b;
            mux_tag_s = req0_tag;
        end
    end

    alu u_alu (
        .op     (mux_op_s),
        .a      (mux_a_s),
        .b      (mux_b_s),
        .result (alu_result_s)
    );

    assign illegal_s = !is_legal_alu_op(mux_op_s);

    // Response register, grant history and contention counter
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r   <= REQ_AUX;
            rsp_valid_r    <= 1'b0;
            rsp_id_r       <= REQ_EX;
            rsp_tag_r      <= {TAG_W{1'b0}};
            rsp_result_r   <= 32'h0000_0000;
            rsp_zero_r     <= 1'b0;
            rsp_illegal_r  <= 1'b0;
            conflict_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (grant_valid_s) begin
                last_grant_r  <= grant_id_s;
                rsp_valid_r   <= 1'b1;
                rsp_id_r      <= grant_id_s;
                rsp_tag_r     <= mux_tag_s;
                rsp_result_r  <= alu_result_s;
                rsp_zero_r    <= (alu_result_s == 32'h0000_0000);
                rsp_illegal_r <= illegal_s;
            end else if (rsp_ready) begin
                rsp_valid_r <= 1'b0;
            end else begin
                rsp_valid_r <= rsp_valid_r;
            end
            // Only grants under contention count; stalls and saturation hold the value.
            if (grant_valid_s && both_valid_s && (conflict_cnt_r != {CNT_W{1'b1}})) begin
                conflict_cnt_r <= conflict_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                conflict_cnt_r <= conflict_cnt_r;
            end
        end
    end

    assign rsp_valid    = rsp_valid_r;
    assign rsp_id       = rsp_id_r;
    assign rsp_tag      = rsp_tag_r;
    assign rsp_result   = rsp_result_r;
    assign rsp_zero     = rsp_zero_r;
    assign rsp_illegal  = rsp_illegal_r;
    assign conflict_cnt = conflict_cnt_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios followed by random traffic, all checked
// against a transaction-level model of arbitration, response slot and ALU arithmetic.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [10:0] req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_tag, req1_tag;
    logic        rsp_ready;

    logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zero, rsp_illegal;
    logic [3:0]  rsp_tag;
    logic [31:0] rsp_result;
    logic [15:0] conflict_cnt;

    logic        s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id, s_rsp_zero, s_rsp_illegal;
    logic [3:0]  s_rsp_tag;
    logic [31:0] s_rsp_result;
    logic [1:0]  s_conflict_cnt;

    alu_arbiter #(.TAG_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal),
        .conflict_cnt(conflict_cnt)
    );

    // Narrow-counter instance on the same stimulus to exercise saturation.
    alu_arbiter #(.TAG_W(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id), .rsp_tag(s_rsp_tag),
        .rsp_result(s_rsp_result), .rsp_zero(s_rsp_zero), .rsp_illegal(s_rsp_illegal),
        .conflict_cnt(s_conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model state
    bit          m_valid = 1'b0;
    int          m_last  = 1;
    int          m_id    = 0;
    logic [3:0]  m_tag   = 4'h0;
    logic [31:0] m_res   = 32'h0;
    bit          m_zero  = 1'b0;
    bit          m_ill   = 1'b0;
    int          m_cnt   = 0;
    int          g       = -1;

    task automatic ref_alu(input logic [10:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output bit ill);
        int sh;
        sh  = int'(b[4:0]);
        ill = 1'b0;
        case (op)
            11'h000: r = a + b;
            11'h200: r = a - b;
            11'h001: r = a << sh;
            11'h002: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            11'h004: r = a ^ b;
            11'h005: r = a >> sh;
            11'h205: r = $signed(a) >>> sh;
            11'h006: r = a | b;
            11'h007: r = a & b;
            default: begin r = 32'd0; ill = 1'b1; end
        endcase
    endtask

    // One clock: check readies before the edge, advance the model, check the slot after.
    task automatic cycle();
        bit          both;
        logic [10:0] op;
        logic [31:0] a, b, r;
        logic [3:0]  t;
        bit          ill;
        #1;
        g    = -1;
        both = req0_valid && req1_valid;
        if (!rst && (!m_valid || rsp_ready)) begin
            if (both) g = 1 - m_last;
            else if (req0_valid) g = 0;
            else if (req1_valid) g = 1;
        end
        check_eq("req0_ready", req0_ready, g == 0);
        check_eq("req1_ready", req1_ready, g == 1);
        check_eq("sat_ready", {s_req0_ready, s_req1_ready}, {g == 0, g == 1});
        op = (g == 1) ? req1_op  : req0_op;
        a  = (g == 1) ? req1_a   : req0_a;
        b  = (g == 1) ? req1_b   : req0_b;
        t  = (g == 1) ? req1_tag : req0_tag;
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_last = 1; m_cnt = 0; m_id = 0;
            m_tag = 4'h0; m_res = 32'h0; m_zero = 1'b0; m_ill = 1'b0;
        end else if (g >= 0) begin
            ref_alu(op, a, b, r, ill);
            m_res = r; m_ill = ill; m_zero = (r == 32'h0);
            m_id = g; m_tag = t; m_valid = 1'b1; m_last = g;
            if (both) m_cnt++;
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check_eq("rsp_valid", rsp_valid, m_valid);
        check_eq("rsp_id", rsp_id, m_id[0]);
        check_eq("rsp_tag", rsp_tag, m_tag);
        check_eq("rsp_result", rsp_result, m_res);
        check_eq("rsp_zero", rsp_zero, m_zero);
        check_eq("rsp_illegal", rsp_illegal, m_ill);
        check_eq("conflict_cnt", conflict_cnt, (m_cnt > 65535) ? 65535 : m_cnt);
        check_eq("sat_conflict_cnt", s_conflict_cnt, (m_cnt > 3) ? 3 : m_cnt);
        check_eq("sat_rsp", {s_rsp_valid, s_rsp_id, s_rsp_tag, s_rsp_result, s_rsp_zero, s_rsp_illegal},
                 {m_valid, m_id[0], m_tag, m_res, m_zero, m_ill});
        @(negedge clk);
    endtask

    task automatic drv(input int n, input logic v, input logic [10:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        if (n == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_tag = t;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_tag = t;
        end
    endtask

    logic [10:0] legal_ops [9] = '{11'h000, 11'h200, 11'h001, 11'h002, 11'h004,
                                   11'h005, 11'h205, 11'h006, 11'h007};

    initial begin
        logic [10:0] rop;
        rst = 1'b1; rsp_ready = 1'b1;

        // Reset held two cycles with both requesters valid
        drv(0, 1'b1, 11'h200, 32'd5, 32'd5, 4'h1);
        drv(1, 1'b1, 11'h205, 32'h8000_0000, 32'd4, 4'h2);
        cycle(); cycle();
        check_eq("reset_cnt", conflict_cnt, 16'd0);

        // Alternation: grants 0,1,0,1
        rst = 1'b0;
        cycle();
        check_eq("alt_sub_zero", {rsp_result, rsp_zero, rsp_id}, {32'h0, 1'b1, 1'b0});
        cycle();
        check_eq("alt_sra", {rsp_result, rsp_id}, {32'hF800_0000, 1'b1});
        cycle(); cycle();
        check_eq("alt_cnt", conflict_cnt, 16'd4);
        check_eq("alt_sat_cnt", s_conflict_cnt, 2'd3);

        // Single op, signed overflow wraps
        drv(1, 1'b0, 11'h000, 32'h0, 32'h0, 4'h0);
        drv(0, 1'b1, 11'h000, 32'h7FFF_FFFF, 32'd1, 4'h3);
        cycle();
        check_eq("add_wrap", {rsp_result, rsp_zero, rsp_id, rsp_tag}, {32'h8000_0000, 1'b0, 1'b0, 4'h3});

        // Backpressure: response held, req1 waits, then accepted with no bubble
        drv(0, 1'b1, 11'h006, 32'h00F0, 32'h0F00, 4'h4);
        cycle();
        drv(0, 1'b0, 11'h000, 32'h0, 32'h0, 4'h0);
        drv(1, 1'b1, 11'h004, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'h9);
        rsp_ready = 1'b0;
        cycle(); cycle(); cycle();
        check_eq("bp_hold", {rsp_valid, rsp_result, rsp_tag}, {1'b1, 32'h0000_0FF0, 4'h4});
        rsp_ready = 1'b1;
        cycle();
        check_eq("bp_refill", {rsp_valid, rsp_id, rsp_result}, {1'b1, 1'b1, 32'hF0F0_0F0F});

        // Illegal opcode, then signed compare
        drv(1, 1'b1, 11'h7FF, 32'h1234_5678, 32'h1, 4'hA);
        cycle();
        check_eq("illegal", {rsp_result, rsp_zero, rsp_illegal}, {32'h0, 1'b1, 1'b1});
        drv(1, 1'b1, 11'h002, 32'hFFFF_FFFF, 32'd1, 4'hB);
        cycle();
        check_eq("slt", {rsp_result, rsp_illegal}, {32'd1, 1'b0});

        // Reset with a response held: it must be discarded
        drv(1, 1'b0, 11'h000, 32'h0, 32'h0, 4'h0);
        drv(0, 1'b1, 11'h000, 32'd10, 32'd20, 4'hC);
        rsp_ready = 1'b0;
        cycle();
        drv(0, 1'b0, 11'h000, 32'h0, 32'h0, 4'h0);
        rst = 1'b1;
        cycle();
        check_eq("midrst_valid", rsp_valid, 1'b0);
        rst = 1'b0; rsp_ready = 1'b1;
        cycle();
        check_eq("midrst_dropped", rsp_valid, 1'b0);

        // Random traffic; requesters hold their operation until granted
        for (int i = 0; i < 600; i++) begin
            for (int n = 0; n < 2; n++) begin
                logic v;
                v = (n == 0) ? req0_valid : req1_valid;
                if (!(v && g != n)) begin
                    rop = ($urandom_range(0, 9) == 0) ? 11'($urandom) : legal_ops[$urandom_range(0, 8)];
                    drv(n, ($urandom_range(0, 3) != 0), rop, $urandom,
                        ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                        4'($urandom));
                end
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 63) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational integer ALU (sub-module alu) between two requesters.
  - Requester 0: the execute-stage integer pipeline.
  - Requester 1: the auxiliary address/CSR helper path.
- Arbitrates round-robin and drives the shared ALU with the winner's operands.
- Captures the result in a one-entry response register with a valid/ready handshake.
- Keeps a saturating contention counter for performance analysis.

Parameters:
- TAG_W, 4, width of the opaque requester tag carried from request to response.
- CNT_W, 16, width of the saturating contention counter.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_op  input  11  ALU opcode, {funct7, 1'b0, funct3} encoding.
- req0_a  input  32  operand 1.
- req0_b  input  32  operand 2.
- req0_tag  input  TAG_W  returned unchanged on the response.
- req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_tag: same as requester 0.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer takes the response.
- rsp_id  output  1  requester that issued the response.
- rsp_tag  output  TAG_W  tag of that request.
- rsp_result  output  32  ALU result.
- rsp_zero  output  1  result == 0.
- rsp_illegal  output  1  opcode was not one of the 9 legal encodings (result is 0).
- conflict_cnt  output  CNT_W  cycles in which both requesters were valid and one was accepted; saturates at all-ones.

Behaviour:
- Reset (rst=1 at a rising edge):
  - rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_result=0, rsp_zero=0, rsp_illegal=0.
  - conflict_cnt=0; last_grant=1, so requester 0 wins first.
  - req*_ready read 0 while rst is high.
- Reset mid-operation: a held response is discarded. Requesters keep valid high and are re-arbitrated after reset.
- Slot free condition: can_accept = !rsp_valid || rsp_ready. This is a combinational bypass, so back-to-back throughput is 1 op/cycle.
- Grant (combinational, only when can_accept and not in reset):
  - Only reqN_valid high -> grant N.
  - Both valid -> grant the requester that is not last_grant.
  - Neither valid -> no grant.
- reqN_ready = can_accept && grant==N. At most one ready is high per cycle.
- Ready may depend on valid. Valid must not depend on ready.
- Transfer occurs at the edge where valid && ready. On transfer:
  - The ALU is fed the granted op/a/b (mux before alu).
  - The response register loads result, zero, illegal, tag and id.
  - rsp_valid is set; last_grant <= N.
- Latency: request accepted at edge k -> rsp_valid high after edge k. Exactly 1 cycle.
- Response hold: if rsp_valid && !rsp_ready, all rsp_* fields hold stable, both ready outputs are 0, and last_grant is unchanged.
- Drain without refill: rsp_ready=1 with no new grant -> rsp_valid <= 0 at the edge.
- Simultaneous drain and refill: rsp_ready=1 and a grant in the same cycle -> the register reloads with no bubble and rsp_valid stays 1.
- Requester rule: once reqN_valid is high, it stays high with op/a/b/tag stable until reqN_ready. The bench asserts this. The block does not re-check it.
- Contention counter:
  - Increments on a cycle where both valid and a grant occurs.
  - A stall cycle (no grant) does not count.
  - At all-ones it holds.
- Illegal-opcode check: compare against package constants, combinational on the granted op.
- ALU arithmetic is fixed by alu:
  - 32-bit wrap-around add/sub.
  - Shift amount = b[4:0].
  - SLT is signed.
  - SRA is arithmetic.

Decomposition:
- Package alu_pkg:
  - Opcode localparams ALU_ADD=11'h000, ALU_SUB=11'h200, ALU_SLL=11'h001, ALU_SLT=11'h002, ALU_XOR=11'h004, ALU_SRL=11'h005, ALU_SRA=11'h205, ALU_OR=11'h006, ALU_AND=11'h007.
  - Function is_legal_alu_op.
  - Requester-id typedef req_id_t (1 bit).
- Sub-module: one existing alu instance. The arbiter FSM, mux and response register stay in alu_arbiter.

Test Plan:
- Reset: hold rst 2 cycles with both requesters valid -> rsp_valid=0, conflict_cnt=0, both ready=0.
  - First cycle after reset: req0_ready=1, req1_ready=0.
- Single op: req0 ADD a=32'h7FFF_FFFF, b=1, tag=3, rsp_ready=1.
  - Next cycle: rsp_result=32'h8000_0000, rsp_zero=0, rsp_id=0, rsp_tag=3.
- Alternation: both valid continuously for 4 cycles (req0 SUB 5-5, req1 SRA 32'h8000_0000 >>> 4), rsp_ready=1.
  - Grants go 0,1,0,1.
  - Responses: 0 with zero=1; 32'hF800_0000 with id=1.
  - conflict_cnt=4.
- Backpressure: rsp_ready=0 for 3 cycles with a response held and req1 valid.
  - rsp_* stable, req1_ready=0, conflict_cnt unchanged.
  - rsp_ready=1 -> req1 accepted the same cycle, and the new response appears with no bubble.
- Illegal opcode: req1 op=11'h7FF -> rsp_result=0, rsp_zero=1, rsp_illegal=1.
  - Following SLT -1<1 -> result=1, rsp_illegal=0.
- Saturation and reset mid-flight: with CNT_W=2, 5 contended grants -> conflict_cnt=3.
  - Assert rst while rsp_valid=1 -> rsp_valid=0 the next cycle, and the response is never delivered.
